// File: rtl/ethernet_mmio_arbiter.sv
`timescale 1ns/1ps
// ethernet_mmio_arbiter
// ---------------------
// Shares the Ethernet controller MMIO decoder port between two requesters
// (port 0: core I/O path, port 1: debug/host bridge). One request is in
// flight at a time. When both ports ask at once, the grant goes to the port
// that did not win last time. The accepted request is issued to the decoder
// as a single-cycle read or write strobe. The decoder's registered read data
// and its decode error are captured, and the response is returned to the
// owning port over a valid/ready handshake.
//
// Ports
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   req_*_i / req_ready_and_o per-port request channel (port p = slice p)
//   resp_*                    per-port response valid/ready, shared data/err
//   addr_o, read_en_o, write_en_o, op_size_o, write_data_o
//                             decoder request, zero outside the issue cycle
//   read_data_i               decoder read data, valid the cycle after read_en_o
//   io_decode_error_i         decoder error, valid with the strobe
//   busy_o                    arbiter not idle
//   err_cnt_o                 saturating count of decode errors
module ethernet_mmio_arbiter #(
    parameter int data_width_p    = 32,
    parameter int addr_width_p    = 14,
    parameter int size_width_p    = 2,
    parameter int err_cnt_width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [1:0]                 req_v_i,
    output logic [1:0]                 req_ready_and_o,
    input  logic [1:0]                 req_we_i,
    input  logic [2*addr_width_p-1:0]  req_addr_i,
    input  logic [2*size_width_p-1:0]  req_size_i,
    input  logic [2*data_width_p-1:0]  req_data_i,
    output logic [1:0]                 resp_v_o,
    input  logic [1:0]                 resp_ready_and_i,
    output logic [data_width_p-1:0]    resp_data_o,
    output logic                       resp_err_o,
    output logic [addr_width_p-1:0]    addr_o,
    output logic                       read_en_o,
    output logic                       write_en_o,
    output logic [size_width_p-1:0]    op_size_o,
    output logic [data_width_p-1:0]    write_data_o,
    input  logic [data_width_p-1:0]    read_data_i,
    input  logic                       io_decode_error_i,
    output logic                       busy_o,
    output logic [err_cnt_width_p-1:0] err_cnt_o
);

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_ISSUE   = 2'd1;
    localparam logic [1:0] STATE_CAPTURE = 2'd2;
    localparam logic [1:0] STATE_RESP    = 2'd3;

    logic [1:0]                 state_reg;
    logic [1:0]                 state_next;
    logic                       last_grant_reg;
    logic                       owner_reg;
    logic                       we_reg;
    logic [addr_width_p-1:0]    addr_reg;
    logic [size_width_p-1:0]    size_reg;
    logic [data_width_p-1:0]    wdata_reg;
    logic [data_width_p-1:0]    data_reg;
    logic                       err_reg;
    logic [err_cnt_width_p-1:0] err_cnt_reg;

    // Per-port views of the packed request buses
    logic                    port_we    [2];
    logic [addr_width_p-1:0] port_addr  [2];
    logic [size_width_p-1:0] port_size  [2];
    logic [data_width_p-1:0] port_data  [2];

    logic in_idle;
    logic in_issue;
    logic in_resp;
    logic grant_valid;
    logic grant_id;
    logic resp_fire;

    assign in_idle  = (state_reg == STATE_IDLE);
    assign in_issue = (state_reg == STATE_ISSUE);
    assign in_resp  = (state_reg == STATE_RESP);

    // A lone requester always wins; under contention the port that did not
    // win last time is favoured.
    assign grant_valid = |req_v_i;
    assign grant_id    = (&req_v_i) ? ~last_grant_reg : req_v_i[1];

    // Only the owner's ready can complete a response.
    assign resp_fire = in_resp && resp_ready_and_i[owner_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign port_we[gi]   = req_we_i[gi];
            assign port_addr[gi] = req_addr_i[gi*addr_width_p +: addr_width_p];
            assign port_size[gi] = req_size_i[gi*size_width_p +: size_width_p];
            assign port_data[gi] = req_data_i[gi*data_width_p +: data_width_p];

            // Ready is offered only to the granted port, so a grant equals a
            // handshake while idle.
            assign req_ready_and_o[gi] = in_idle && grant_valid && (grant_id == 1'(gi));
            assign resp_v_o[gi]        = in_resp && (owner_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STATE_IDLE:    if (grant_valid) state_next = STATE_ISSUE;
            STATE_ISSUE:   state_next = we_reg ? STATE_RESP : STATE_CAPTURE;
            STATE_CAPTURE: state_next = STATE_RESP;
            STATE_RESP:    if (resp_fire) state_next = STATE_IDLE;
            default:       state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg      <= STATE_IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            size_reg       <= '0;
            wdata_reg      <= '0;
            data_reg       <= '0;
            err_reg        <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;

            if (in_idle && grant_valid) begin
                owner_reg      <= grant_id;
                last_grant_reg <= grant_id;
                we_reg         <= port_we[grant_id];
                addr_reg       <= port_addr[grant_id];
                size_reg       <= port_size[grant_id];
                wdata_reg      <= port_data[grant_id];
            end

            if (in_issue) begin
                err_reg <= io_decode_error_i;
                // Writes never pass through CAPTURE, so clear the data here.
                if (we_reg) begin
                    data_reg <= '0;
                end
                if (io_decode_error_i && (err_cnt_reg != '1)) begin
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                end
            end

            if (state_reg == STATE_CAPTURE) begin
                data_reg <= read_data_i;
            end
        end
    end

    // Decoder request lines are held at zero outside the issue cycle.
    assign addr_o       = in_issue ? addr_reg  : '0;
    assign op_size_o    = in_issue ? size_reg  : '0;
    assign write_data_o = in_issue ? wdata_reg : '0;
    assign read_en_o    = in_issue && !we_reg;
    assign write_en_o   = in_issue && we_reg;

    assign resp_data_o = (in_resp && !err_reg) ? data_reg : '0;
    assign resp_err_o  = in_resp && err_reg;
    assign busy_o      = !in_idle;
    assign err_cnt_o   = err_cnt_reg;

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
`timescale 1ns/1ps
// Directed testbench for ethernet_mmio_arbiter. Includes a small decoder
// model: read data is registered one cycle after read_en_o, and the error
// flag is combinational with the strobe.
module tb_ethernet_mmio_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [1:0]  req_v_i;
    logic [1:0]  req_ready_and_o;
    logic [1:0]  req_we_i;
    logic [27:0] req_addr_i;
    logic [3:0]  req_size_i;
    logic [63:0] req_data_i;
    logic [1:0]  resp_v_o;
    logic [1:0]  resp_ready_and_i;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic [13:0] addr_o;
    logic        read_en_o;
    logic        write_en_o;
    logic [1:0]  op_size_o;
    logic [31:0] write_data_o;
    logic [31:0] read_data_i;
    logic        io_decode_error_i;
    logic        busy_o;
    logic [7:0]  err_cnt_o;

    logic [31:0] dec_value;
    logic        dec_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ethernet_mmio_arbiter dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .req_v_i           (req_v_i),
        .req_ready_and_o   (req_ready_and_o),
        .req_we_i          (req_we_i),
        .req_addr_i        (req_addr_i),
        .req_size_i        (req_size_i),
        .req_data_i        (req_data_i),
        .resp_v_o          (resp_v_o),
        .resp_ready_and_i  (resp_ready_and_i),
        .resp_data_o       (resp_data_o),
        .resp_err_o        (resp_err_o),
        .addr_o            (addr_o),
        .read_en_o         (read_en_o),
        .write_en_o        (write_en_o),
        .op_size_o         (op_size_o),
        .write_data_o      (write_data_o),
        .read_data_i       (read_data_i),
        .io_decode_error_i (io_decode_error_i),
        .busy_o            (busy_o),
        .err_cnt_o         (err_cnt_o)
    );

    // Decoder model: garbage unless a read strobe was seen on the last edge.
    always @(posedge clk_i) begin
        read_data_i <= read_en_o ? dec_value : 32'hDEAD_BEEF;
    end
    assign io_decode_error_i = (read_en_o | write_en_o) & dec_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_port(input int p, input logic we, input logic [13:0] addr,
                              input logic [1:0] size, input logic [31:0] data);
        req_we_i[p]           = we;
        req_addr_i[p*14 +: 14] = addr;
        req_size_i[p*2 +: 2]   = size;
        req_data_i[p*32 +: 32] = data;
    endtask

    task automatic do_reset();
        reset_n_i        = 1'b0;
        req_v_i          = 2'b00;
        resp_ready_and_i = 2'b00;
        step();
        step();
        check("rst_busy",    64'(busy_o),          64'd0);
        check("rst_resp_v",  64'(resp_v_o),        64'd0);
        check("rst_ready",   64'(req_ready_and_o), 64'd0);
        check("rst_strobes", 64'({read_en_o, write_en_o}), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o),       64'd0);
        reset_n_i = 1'b1;
        step();
    endtask

    // Single transaction from port p, entered and left in IDLE at posedge+1.
    task automatic run_txn(input int p, input logic we, input logic [13:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic derr,
                           input logic [31:0] exp_data, input logic exp_err);
        logic [1:0] onehot;
        onehot    = (p == 0) ? 2'b01 : 2'b10;
        dec_value = rdata;
        dec_err   = derr;
        drive_port(p, we, addr, size, wdata);
        req_v_i = onehot;
        #1;
        check("grant", 64'(req_ready_and_o), 64'(onehot));
        step();                                   // T+1: ISSUE
        req_v_i = 2'b00;
        check("issue_rd_en",  64'(read_en_o),    64'(!we));
        check("issue_wr_en",  64'(write_en_o),   64'(we));
        check("issue_addr",   64'(addr_o),       64'(addr));
        check("issue_size",   64'(op_size_o),    64'(size));
        check("issue_wdata",  64'(write_data_o), 64'(wdata));
        check("issue_busy",   64'(busy_o),       64'd1);
        if (!we) begin
            step();                               // T+2: CAPTURE
            check("capt_resp_v", 64'(resp_v_o), 64'd0);
            check("capt_strobe", 64'({read_en_o, write_en_o}), 64'd0);
        end
        step();                                   // response cycle
        check("resp_v",    64'(resp_v_o),    64'(onehot));
        check("resp_data", 64'(resp_data_o), 64'(exp_data));
        check("resp_err",  64'(resp_err_o),  64'(exp_err));
        check("idle_dec_addr", 64'(addr_o),  64'd0);
        resp_ready_and_i = onehot;
        step();
        resp_ready_and_i = 2'b00;
        check("post_resp_v", 64'(resp_v_o), 64'd0);
        check("post_busy",   64'(busy_o),   64'd0);
        $display("txn port=%0d we=%0d addr=0x%04h data=0x%08h err=%0d err_cnt=%0d",
                 p, we, addr, exp_data, exp_err, err_cnt_o);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_we_i   = '0;
        req_addr_i = '0;
        req_size_i = '0;
        req_data_i = '0;
        dec_value  = '0;
        dec_err    = 1'b0;
        do_reset();

        // Single read and single write
        run_txn(0, 1'b0, 14'h1004, 2'd2, 32'h0, 32'h0000_05DC, 1'b0, 32'h0000_05DC, 1'b0);
        run_txn(1, 1'b1, 14'h1028, 2'd2, 32'h40, 32'h1111_2222, 1'b0, 32'h0, 1'b0);

        // Contention: both ports valid for four requests, grants 0,1,0,1
        do_reset();
        drive_port(0, 1'b0, 14'h0100, 2'd2, 32'h0);
        drive_port(1, 1'b0, 14'h0200, 2'd2, 32'h0);
        req_v_i = 2'b11;
        dec_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int          g;
            logic [1:0]  oh;
            logic [31:0] v;
            g  = i % 2;
            oh = (g == 0) ? 2'b01 : 2'b10;
            v  = 32'hA000_0000 + 32'(i);
            dec_value = v;
            #1;
            check("rr_grant", 64'(req_ready_and_o), 64'(oh));
            step();
            check("rr_rd_en", 64'(read_en_o), 64'd1);
            check("rr_addr",  64'(addr_o), (g == 0) ? 64'h0100 : 64'h0200);
            check("rr_busy_ready", 64'(req_ready_and_o), 64'd0);
            step();
            step();
            check("rr_resp_v",    64'(resp_v_o),    64'(oh));
            check("rr_resp_data", 64'(resp_data_o), 64'(v));
            resp_ready_and_i = oh;
            step();
            resp_ready_and_i = 2'b00;
            check("rr_idle_strobe", 64'(read_en_o), 64'd0);
            check("rr_idle_busy",   64'(busy_o),    64'd0);
            $display("txn rr=%0d port=%0d data=0x%08h", i, g, resp_data_o === 32'h0 ? v : resp_data_o);
        end
        req_v_i = 2'b00;

        // Response stall: owner holds ready low, non-owner ready is ignored
        dec_value = 32'hCAFE_F00D;
        drive_port(0, 1'b0, 14'h1008, 2'd2, 32'h0);
        req_v_i = 2'b01;
        #1;
        check("stall_grant", 64'(req_ready_and_o), 64'd1);
        step();
        req_v_i = 2'b10;
        check("stall_issue_ready", 64'(req_ready_and_o), 64'd0);
        step();
        step();
        resp_ready_and_i = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_resp_v", 64'(resp_v_o),        64'd1);
            check("stall_data",   64'(resp_data_o),     64'hCAFE_F00D);
            check("stall_ready",  64'(req_ready_and_o), 64'd0);
            check("stall_busy",   64'(busy_o),          64'd1);
        end
        resp_ready_and_i = 2'b01;
        step();
        resp_ready_and_i = 2'b00;
        check("stall_next_grant", 64'(req_ready_and_o), 64'd2);
        req_v_i = 2'b00;            // requester withdraws before handshake
        #1;
        check("drop_ready", 64'(req_ready_and_o), 64'd0);
        step();
        check("drop_busy", 64'(busy_o), 64'd0);
        $display("txn stall port=0 addr=0x1008 data=0xcafef00d");

        // Decode errors: count and saturate
        do_reset();
        run_txn(0, 1'b0, 14'h1014, 2'd2, 32'h0, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
        check("err_cnt_one", 64'(err_cnt_o), 64'd1);
        for (int i = 1; i < 300; i++) begin
            run_txn(i % 2, 1'b0, 14'h1014, 2'd2, 32'h0, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
            if (i == 254) check("err_cnt_255", 64'(err_cnt_o), 64'd255);
        end
        check("err_cnt_sat", 64'(err_cnt_o), 64'd255);

        // Reset asserted while in CAPTURE
        dec_err   = 1'b0;
        dec_value = 32'h0000_0077;
        drive_port(0, 1'b0, 14'h1004, 2'd2, 32'h0);
        req_v_i = 2'b01;
        step();
        req_v_i = 2'b00;
        step();
        check("capt_busy", 64'(busy_o), 64'd1);
        reset_n_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        check("rstc_busy",    64'(busy_o),    64'd0);
        check("rstc_resp_v",  64'(resp_v_o),  64'd0);
        check("rstc_err_cnt", 64'(err_cnt_o), 64'd0);
        step();
        check("rstc_stay_idle", 64'(resp_v_o), 64'd0);
        run_txn(1, 1'b0, 14'h1028, 2'd1, 32'h0, 32'h0000_BEEF, 1'b0, 32'h0000_BEEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ethernet_mmio_arbiter.md
# ethernet_mmio_arbiter

Two-port MMIO arbiter that shares the single Ethernet controller MMIO decoder port between two requesters (port 0: core I/O path; port 1: debug/host bridge). It accepts one request at a time with round-robin priority, issues it to the decoder as a one-cycle read/write strobe, and captures the decoder's synchronous read data and decode error. It then returns a response to the owning requester over a valid/ready handshake. It sits directly in front of the MMIO decoder and is the only block driving its enables.

## Interface
- data_width_p, 32, MMIO data width; only 32 is supported.
- addr_width_p, 14, MMIO byte address width, matching the decoder.
- size_width_p, 2, op-size field width: 0=1B, 1=2B, 2=4B.
- err_cnt_width_p, 8, width of the saturating decode-error counter.
- clk_i  in  1  single clock; all state updates on the rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- req_v_i  in  2  per-port request valid.
- req_ready_and_o  out  2  per-port request ready; at most one bit high.
- req_we_i  in  2  per-port write (1) / read (0).
- req_addr_i  in  2*addr_width_p  per-port address; port p occupies slice p.
- req_size_i  in  2*size_width_p  per-port op size.
- req_data_i  in  2*data_width_p  per-port write data.
- resp_v_o  out  2  per-port response valid; at most one bit high.
- resp_ready_and_i  in  2  per-port response ready.
- resp_data_o  out  data_width_p  read data, shared by both ports; 0 for writes and errors.
- resp_err_o  out  1  decode error flag for the response.
- addr_o  out  addr_width_p  decoder address.
- read_en_o  out  1  decoder read strobe.
- write_en_o  out  1  decoder write strobe.
- op_size_o  out  size_width_p  decoder op size.
- write_data_o  out  data_width_p  decoder write data.
- read_data_i  in  data_width_p  decoder read data; valid the cycle after read_en_o.
- io_decode_error_i  in  1  decoder error; valid in the same cycle as the strobe.
- busy_o  out  1  high in any state other than IDLE.
- err_cnt_o  out  err_cnt_width_p  saturating count of decode errors.

## Operation
- State machine has four states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready_and_o is asserted only to the granted port.
  - Grant goes to the single valid port.
  - If both ports are valid, grant goes to the port that is not last_grant_r.
  - On handshake, latch we, addr, size and data and the owner id, update last_grant_r, then go to ISSUE.
- ISSUE (exactly one cycle):
  - Drive addr_o, op_size_o and write_data_o from the latched request.
  - Assert read_en_o or write_en_o; never both.
  - Register io_decode_error_i into err_r.
  - Reads go to CAPTURE; writes go to RESP.
- CAPTURE (exactly one cycle): register read_data_i into data_r, then go to RESP.
- RESP:
  - Assert resp_v_o[owner].
  - resp_data_o = err_r ? 0 : data_r; for writes data_r = 0.
  - resp_err_o = err_r.
  - On resp_ready_and_i[owner], go to IDLE.
  - resp_ready_and_i of the non-owner port is ignored.
- Decoder outputs are zero in every state except ISSUE.
- err_cnt_o increments by 1 in each ISSUE cycle where io_decode_error_i=1 and saturates at all-ones.
- Requests are never dropped or reordered, and there is at most one outstanding request.
- Reset values:
  - State = IDLE.
  - last_grant_r = 1, so port 0 wins the first contention.
  - err_r, data_r and err_cnt_o = 0.
  - All valid, ready and enable outputs = 0.

## Timing
- Request accepted in cycle T:
  - ISSUE strobe in T+1.
  - Read response: resp_v_o from T+3.
  - Write response: resp_v_o from T+2.
  - resp_v_o holds until ready.
- Minimum spacing between requests:
  - Back-to-back reads: next accept in T+4 when the response is accepted in T+3.
  - Back-to-back writes: next accept in T+3.
- A request arriving while the arbiter is not in IDLE waits; ready stays 0.
- A response accepted in the same cycle a new request is valid does not accept that request; acceptance happens the next cycle (IDLE).
- A requester dropping req_v_i before handshake is legal and is not granted.
- Reset low mid-operation: the state returns to IDLE on that edge and any pending response is discarded. A strobe in that cycle is still visible combinationally, but no state persists.

## Test plan
- Single read, port 0, addr 0x1004, decoder returns 0x0000_05DC at T+2 -> resp_v_o[0] at T+3, resp_data_o=0x5DC, resp_err_o=0, read_en_o high only in T+1.
- Single write, port 1, addr 0x1028, data 0x40 -> write_en_o in T+1 with addr_o=0x1028 and write_data_o=0x40; resp_v_o[1] at T+2 with resp_data_o=0.
- Both ports valid continuously for 4 requests after reset -> grants alternate 0,1,0,1, and each grant happens only after the previous response is accepted.
- Read of 0x1014 with decoder error high -> resp_err_o=1, resp_data_o=0, err_cnt_o=1.
  - Repeat 300 times -> err_cnt_o saturates at 255.
- resp_ready_and_i[owner] held low for 10 cycles -> resp_v_o and resp_data_o stay stable, no new grant is made, busy_o=1.
- reset_n_i low in CAPTURE -> next cycle state is IDLE, resp_v_o=0 and err_cnt_o=0; a fresh request then completes normally.
